// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: computes a + b + cin one bit pair per clock, LSB first,
//   through a single full-adder cell (fa_str). An addition is accepted in IDLE,
//   runs for WIDTH cycles in RUN, and then presents the result for one cycle
//   in DONE.
//
// Ports
//   clk    - single clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   start  - begin an addition; sampled only in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   busy   - high whenever the FSM is not in IDLE
//   done   - one-cycle pulse; sum/cout hold the new result
//   sum    - registered a+b+cin mod 2^WIDTH; changes only on entry to DONE
//   cout   - registered carry-out of the full WIDTH-bit addition
// -----------------------------------------------------------------------------

// Full-adder cell used for every bit position of the serial addition.
module fa_str (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  logic p;

  assign p  = x ^ y;
  assign s  = p ^ c;
  assign co = (x & y) | (c & p);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One spare bit so the counter can never wrap within an operation.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  fa_str u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result register fills from the MSB side, so after WIDTH shifts the first
  // (LSB) sum bit has arrived at bit 0.
  assign res_next = {fa_s, res_sr[WIDTH-1:1]};

  // NOTE: every register below is assigned with <= so all state updates see
  // the pre-edge values; blocking assignments here would create ordering
  // dependent behaviour between the shift registers and the adder inputs.
  // NOTE: the operand/result shift registers are flops, not a memory array,
  // so they are cleared by the asynchronous reset like all other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          res_sr <= res_next;
          carry  <= fa_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // The completed word includes this edge's sum bit, so publish
            // res_next rather than res_sr.
            sum   <= res_next;
            cout  <= fa_co;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder (WIDTH=8). Stimulus tasks push the
//   expected {cout,sum} when an operation is launched; an independent monitor
//   pops and compares on every done pulse. Latency, busy length, start
//   immunity, back-to-back operation, mid-run reset and a random sweep are
//   covered.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sum_cout", 32'({cout, sum}), 32'(e));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Launch one addition with a one-cycle start pulse; operands are scrambled
  // right after the accepting edge. Returns the negedge index (1 = the one
  // just after the accepting edge) at which done is seen and the number of
  // those negedges with busy high.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, output int lat, output int bcyc);
    wait_idle();
    a = ai; b = bi; cin = ci; start = 1'b1;
    exp_q.push_back((W+1)'(ai) + (W+1)'(bi) + (W+1)'(ci));
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ai; b = 8'h5A; cin = ~ci;
    lat = 0;
    bcyc = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) lat = i;
    end
    if (lat == 0) check("done_timeout", 32'(lat), 32'd9);
  endtask

  initial begin
    int lat, bcyc, d0, k, n;
    int dn[3];
    logic hold_ok;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x0F + 0x01: latency, busy length and single-cycle done
    do_op(8'h0F, 8'h01, 1'b0, lat, bcyc);
    check("latency", 32'(lat), 32'd9);
    check("busy_cycles", 32'(bcyc), 32'd9);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);

    // Carry corner cases
    do_op(8'hFF, 8'h01, 1'b0, lat, bcyc);
    do_op(8'hFF, 8'hFF, 1'b1, lat, bcyc);
    do_op(8'h00, 8'h00, 1'b0, lat, bcyc);
    do_op(8'h00, 8'h00, 1'b1, lat, bcyc);

    // start/operand changes during RUN are ignored
    wait_idle();
    d0 = done_cnt;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h046);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);

    // start held high: back-to-back operations every 10 cycles
    wait_idle();
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back(9'h002);
    k = 0;
    n = 0;
    hold_ok = 1'b1;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        dn[k] = n;
        k++;
        if (k == 3) start = 1'b0;
      end else if (k > 0 && sum !== 8'h02) begin
        hold_ok = 1'b0;
      end
    end
    check("held_done_count", 32'(k), 32'd3);
    if (k == 3) begin
      check("period_1", 32'(dn[1] - dn[0]), 32'd10);
      check("period_2", 32'(dn[2] - dn[1]), 32'd10);
    end
    check("sum_hold", 32'(hold_ok), 32'd1);

    // Reset during bit 4 of 0x80 + 0x80 aborts without done or partial sum
    wait_idle();
    d0 = done_cnt;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("sum_hold_run", 32'(sum), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_sum",  32'(sum),  32'd0);
    check("async_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    do_op(8'h80, 8'h80, 1'b0, lat, bcyc);
    check("latency_after_reset", 32'(lat), 32'd9);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), lat, bcyc);
    end

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
